wbvio_debug_regs: RTL and testbench

- Wishbone classic responder (slave) that answers transactions issued by the VIO-driven Wishbone initiator on the debug bus.
- Provides a small debug register window: ID, scratch, debug-select, a cycle counter with snapshot, a status register and an access counter.
- Generates registered ack/err/rty terminations, so the VIO path can be checked end to end without involving the real device registers.

---
 rtl/wbvio_debug_regs_pkg.sv | 34 +++
 rtl/wbvio_debug_regs.sv | 210 +++++++++++++++++++++
 tb/tb_wbvio_debug_regs.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wbvio_debug_regs_pkg.sv
// wbvio_debug_regs_pkg
//   Shared definitions for the Wishbone debug register window.
//   Contents:
//     - word offsets (adr[4:2]) of every register in the window
//     - CTRL strobe bit indices and STATUS field positions
//     - default identification constant
//     - FSM state type
package wbvio_debug_regs_pkg;

  // Word offsets, compared against adr_i[4:2]
  localparam logic [2:0] DBG_ID       = 3'd0;
  localparam logic [2:0] DBG_SCRATCH  = 3'd1;
  localparam logic [2:0] DBG_SEL      = 3'd2;
  localparam logic [2:0] DBG_CTRL     = 3'd3;
  localparam logic [2:0] DBG_SNAPSHOT = 3'd4;
  localparam logic [2:0] DBG_STATUS   = 3'd5;
  localparam logic [2:0] DBG_ACCCNT   = 3'd6;

  // CTRL strobe bits
  localparam int CTRL_SNAP_BIT = 0;
  localparam int CTRL_CLR_BIT  = 1;

  // STATUS fields
  localparam int STATUS_PEND_BIT   = 0;
  localparam int STATUS_ERRCNT_LSB = 8;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h5334_4442;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TERM = 1'b1
  } state_t;

endpackage

// File: rtl/wbvio_debug_regs.sv
// wbvio_debug_regs
//   Wishbone classic responder exposing a 32-byte debug register window
//   (ID, scratch, debug select, cycle counter snapshot, status, access
//   counter). Every accepted access is answered one cycle later with
//   exactly one registered termination (ack/err/rty) lasting one cycle.
// Ports:
//   clk_i        Wishbone clock
//   rst_n_i      asynchronous active-low reset
//   cyc_i/stb_i  cycle / strobe
//   we_i         write enable
//   adr_i[19:0]  byte address, [1:0] ignored
//   dat_i[31:0]  write data
//   dat_o[31:0]  read data, valid while ack_o is high
//   ack_o/err_o/rty_o  terminations
//   debug_sel_o[3:0]   debug multiplexer select
module wbvio_debug_regs
  import wbvio_debug_regs_pkg::*;
#(
  parameter logic [19:0] BASE_ADR    = 20'h00000,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE,
  parameter int unsigned SNAP_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [19:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic [3:0]  debug_sel_o
);

  localparam logic [3:0] SNAP_LOAD = 4'(SNAP_CYCLES);

  state_t      state_reg, state_next;
  logic [31:0] scratch_reg;
  logic [3:0]  sel_reg;
  logic [31:0] cyc_cnt_reg;
  logic [31:0] snapshot_reg;
  logic [3:0]  snap_cnt_reg;
  logic [7:0]  err_cnt_reg;
  logic [31:0] acc_cnt_reg;

  logic        ack_next, err_next, rty_next;
  logic [31:0] rdata_next;
  logic        wr_scratch, wr_sel, ctrl_snap, ctrl_clr;
  logic        hit, pending;
  logic [2:0]  offset;
  logic [31:0] status_word;

  // Byte-lane bits of the address carry no information for word registers.
  logic unused_adr_bits;
  assign unused_adr_bits = ^adr_i[1:0];

  assign hit     = (adr_i[19:5] == BASE_ADR[19:5]);
  assign offset  = adr_i[4:2];
  assign pending = (snap_cnt_reg != 4'd0);

  always_comb begin
    status_word = 32'd0;
    status_word[STATUS_PEND_BIT] = pending;
    status_word[STATUS_ERRCNT_LSB +: 8] = err_cnt_reg;
  end

  // Decode and next-state. Terminations are only produced from IDLE, so the
  // registered outputs fall back to zero in the TERM cycle.
  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    rty_next   = 1'b0;
    rdata_next = 32'd0;
    wr_scratch = 1'b0;
    wr_sel     = 1'b0;
    ctrl_snap  = 1'b0;
    ctrl_clr   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          state_next = ST_TERM;
          if (!hit) begin
            err_next = 1'b1;
          end else begin
            case (offset)
              DBG_ID: begin
                if (we_i) err_next = 1'b1;
                else begin
                  ack_next   = 1'b1;
                  rdata_next = ID_VALUE;
                end
              end
              DBG_SCRATCH: begin
                ack_next = 1'b1;
                if (we_i) wr_scratch = 1'b1;
                else      rdata_next = scratch_reg;
              end
              DBG_SEL: begin
                ack_next = 1'b1;
                if (we_i) wr_sel = 1'b1;
                else      rdata_next = {28'd0, sel_reg};
              end
              DBG_CTRL: begin
                // A second snapshot request while one is pending is retried
                // so the captured value cannot be overwritten unseen.
                if (we_i && dat_i[CTRL_SNAP_BIT] && pending) begin
                  rty_next = 1'b1;
                end else begin
                  ack_next = 1'b1;
                  if (we_i) begin
                    ctrl_snap = dat_i[CTRL_SNAP_BIT];
                    ctrl_clr  = dat_i[CTRL_CLR_BIT];
                  end
                end
              end
              DBG_SNAPSHOT: begin
                if (we_i)         err_next = 1'b1;
                else if (pending) rty_next = 1'b1;
                else begin
                  ack_next   = 1'b1;
                  rdata_next = snapshot_reg;
                end
              end
              DBG_STATUS: begin
                if (we_i) err_next = 1'b1;
                else begin
                  ack_next   = 1'b1;
                  rdata_next = status_word;
                end
              end
              DBG_ACCCNT: begin
                if (we_i) err_next = 1'b1;
                else begin
                  ack_next   = 1'b1;
                  rdata_next = acc_cnt_reg;
                end
              end
              default: err_next = 1'b1;
            endcase
          end
        end
      end
      ST_TERM: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus FSM and terminations
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rty_o     <= 1'b0;
      dat_o     <= 32'd0;
    end else begin
      state_reg <= state_next;
      ack_o     <= ack_next;
      err_o     <= err_next;
      rty_o     <= rty_next;
      dat_o     <= rdata_next;
    end
  end

  // Read/write registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scratch_reg <= 32'd0;
      sel_reg     <= 4'd0;
    end else begin
      if (wr_scratch) scratch_reg <= dat_i;
      if (wr_sel)     sel_reg     <= dat_i[3:0];
    end
  end

  assign debug_sel_o = sel_reg;

  // Cycle counter and snapshot. With both CTRL bits set the clear wins, so
  // the snapshot records zero rather than the old count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_cnt_reg  <= 32'd0;
      snapshot_reg <= 32'd0;
      snap_cnt_reg <= 4'd0;
    end else begin
      cyc_cnt_reg <= ctrl_clr ? 32'd0 : cyc_cnt_reg + 32'd1;
      if (ctrl_snap) begin
        snapshot_reg <= ctrl_clr ? 32'd0 : cyc_cnt_reg;
        snap_cnt_reg <= SNAP_LOAD;
      end else if (pending) begin
        snap_cnt_reg <= snap_cnt_reg - 4'd1;
      end
    end
  end

  // Access and error counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_reg <= 8'd0;
      acc_cnt_reg <= 32'd0;
    end else begin
      if (ack_next) acc_cnt_reg <= acc_cnt_reg + 32'd1;
      if (err_next && err_cnt_reg != 8'd255) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_wbvio_debug_regs.sv
// tb_wbvio_debug_regs
//   Scoreboard bench for wbvio_debug_regs: the driver issues Wishbone
//   accesses, a reference model predicts each termination and pushes it
//   into a queue, and a monitor pops and compares whenever a termination
//   appears on the bus.
module tb_wbvio_debug_regs;

  localparam logic [31:0] ID   = 32'h5334_4442;
  localparam int          SNAP = 4;
  localparam logic [2:0]  T_ACK = 3'b100;
  localparam logic [2:0]  T_ERR = 3'b010;
  localparam logic [2:0]  T_RTY = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [19:0] adr;
  logic [31:0] wdat;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;
  logic [3:0]  debug_sel_o;

  always #5 clk = ~clk;

  wbvio_debug_regs dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .we_i        (we),
    .adr_i       (adr),
    .dat_i       (wdat),
    .dat_o       (dat_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rty_o       (rty_o),
    .debug_sel_o (debug_sel_o)
  );

  typedef struct packed {
    logic [2:0]  term;
    logic        chk;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [19:0] adr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Clock edges since reset; equals the free-running counter value.
  int edge_abs;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_abs <= 0;
    else        edge_abs <= edge_abs + 1;

  // Reference model state
  logic [31:0] m_scratch, m_snap, m_acc;
  logic [3:0]  m_sel;
  int          m_err, m_base, m_pend_until;

  task automatic model_reset();
    m_scratch = 0; m_snap = 0; m_acc = 0; m_sel = 0;
    m_err = 0; m_base = 0; m_pend_until = -1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Called right after the edge that accepts an access; edge_abs still
  // holds the pre-edge count there.
  task automatic model_access(input logic w, input logic [19:0] a, input logic [31:0] d);
    exp_t x;
    int   e;
    logic pend;
    e    = edge_abs;
    pend = (e <= m_pend_until);
    x.adr = a; x.chk = 1'b0; x.data = 0; x.term = T_ERR; x.sel = 0;
    if (a[19:5] == 15'd0) begin
      case (a[4:2])
        3'd0: if (!w) begin x.term = T_ACK; x.chk = 1; x.data = ID; end
        3'd1: begin
          x.term = T_ACK;
          if (w) m_scratch = d; else begin x.chk = 1; x.data = m_scratch; end
        end
        3'd2: begin
          x.term = T_ACK;
          if (w) m_sel = d[3:0]; else begin x.chk = 1; x.data = {28'd0, m_sel}; end
        end
        3'd3: begin
          if (w && d[0] && pend) x.term = T_RTY;
          else begin
            x.term = T_ACK;
            if (w) begin
              if (d[0]) begin
                m_snap = d[1] ? 32'd0 : 32'(e - m_base);
                m_pend_until = e + SNAP;
              end
              if (d[1]) m_base = e + 1;
            end else begin
              x.chk = 1; x.data = 0;
            end
          end
        end
        3'd4: if (!w) begin
          if (pend) x.term = T_RTY;
          else begin x.term = T_ACK; x.chk = 1; x.data = m_snap; end
        end
        3'd5: if (!w) begin
          x.term = T_ACK; x.chk = 1;
          x.data = {16'd0, 8'(m_err), 7'd0, pend};
        end
        3'd6: if (!w) begin x.term = T_ACK; x.chk = 1; x.data = m_acc; end
        default: ;
      endcase
    end
    if (x.term == T_ACK) m_acc = m_acc + 1;
    if (x.term == T_ERR && m_err < 255) m_err++;
    x.sel = m_sel;
    q.push_back(x);
  endtask

  // Entered just after a negedge; leaves just after a negedge with the DUT idle.
  task automatic do_access(input logic w, input logic [19:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    @(posedge clk);
    model_access(w, a, d);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one line per termination seen.
  always @(negedge clk) begin
    if (rst_n && (ack_o || err_o || rty_o)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_term actual=%b required=none", {ack_o, err_o, rty_o});
      end else begin
        exp_t x;
        x = q.pop_front();
        $display("txn adr=%h term=%b dat=%h sel=%h", x.adr, {ack_o, err_o, rty_o}, dat_o, debug_sel_o);
        check($sformatf("term@%h", x.adr), 32'({ack_o, err_o, rty_o}), 32'(x.term));
        if (x.chk) check($sformatf("data@%h", x.adr), dat_o, x.data);
        check($sformatf("sel@%h", x.adr), 32'(debug_sel_o), 32'(x.sel));
      end
    end
  end

  initial begin
    rst_n = 0; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_rty", 32'(rty_o), 0);
    check("rst_dat", dat_o, 0);
    check("rst_sel", 32'(debug_sel_o), 0);
    rst_n = 1;

    // Directed sequence
    do_access(0, 20'h00, 0);
    do_access(1, 20'h04, 32'hDEADBEEF);
    do_access(0, 20'h04, 0);
    do_access(0, 20'h18, 0);
    do_access(0, 20'h18, 0);
    do_access(1, 20'h08, 32'hFFFFFFF5);
    do_access(0, 20'h08, 0);
    do_access(1, 20'h0C, 32'd3);
    do_access(0, 20'h10, 0);
    do_access(0, 20'h14, 0);
    repeat (4) @(negedge clk);
    do_access(0, 20'h10, 0);
    do_access(0, 20'h1C, 0);
    do_access(0, 20'h00100, 0);
    do_access(0, 20'hF0000, 0);
    do_access(1, 20'h00, 32'h1234);
    do_access(0, 20'h14, 0);
    do_access(0, 20'h00, 0);
    // Snapshot without clear captures the running count
    do_access(1, 20'h0C, 32'd1);
    do_access(1, 20'h0C, 32'd1);
    repeat (6) @(negedge clk);
    do_access(0, 20'h10, 0);

    // Strobe held across TERM: only every other cycle is accepted
    cyc = 1; stb = 1; we = 0; adr = 20'h18; wdat = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      if (k % 2 == 0) model_access(0, 20'h18, 0);
    end
    @(negedge clk);
    cyc = 0; stb = 0;
    @(posedge clk);
    @(negedge clk);

    // Randomized accesses with random gaps
    for (int i = 0; i < 200; i++) begin
      logic [19:0] a;
      logic        w;
      logic [31:0] d;
      a = {15'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) a[19:5] = 15'($urandom_range(1, 32767));
      w = 1'($urandom);
      d = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        // stb with cyc low must be ignored
        cyc = 0; stb = 1; we = w; adr = a; wdat = d;
        @(negedge clk);
        stb = 0; we = 0;
      end
      do_access(w, a, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // ERRCNT saturation
    for (int i = 0; i < 260; i++) do_access(0, 20'h1C, 0);
    do_access(0, 20'h14, 0);

    // Reset asserted during TERM drops the ack at once
    cyc = 1; stb = 1; we = 0; adr = 20'h00;
    @(posedge clk);
    #1;
    check("ack_before_rst", 32'(ack_o), 1);
    rst_n = 0;
    #1;
    check("ack_async_drop", 32'(ack_o), 0);
    check("sel_async_clr", 32'(debug_sel_o), 0);
    cyc = 0; stb = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    do_access(0, 20'h04, 0);
    do_access(0, 20'h14, 0);
    do_access(0, 20'h18, 0);
    do_access(0, 20'h00, 0);

    repeat (4) @(negedge clk);
    while (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_term adr=%h actual=none required=%b", x.adr, x.term);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
